// File: rtl/msrv32_lsu_bus.sv
// Load/store bus master: one word-addressed req/ready transaction per access.
// Formats stores, aligns/extends loads, stalls the core, flags errors and timeouts.
module msrv32_lsu_bus #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        mem_wr_req_in,
  input  logic        load_req_in,
  input  logic        misaligned_load_in,
  input  logic        flush_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wstrb_out,
  input  logic        dmem_ready_in,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_err_in,
  output logic        lsu_stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        bus_err_out
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            discard;
  logic [1:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            accept;
  logic            timeout_hit;
  logic            drop;
  logic [31:0]     wdata_fmt;
  logic [3:0]      wstrb_fmt;
  logic [31:0]     shifted;
  logic [31:0]     load_ext;

  assign accept        = (state == IDLE) & ~flush_in &
                         (mem_wr_req_in | (load_req_in & ~misaligned_load_in));
  assign lsu_stall_out = accept | (state == BUSY);
  assign timeout_hit   = (TIMEOUT != 0) && (cnt == TO_LAST);
  // A flush in the completing cycle counts as well as an earlier sticky one.
  assign drop          = discard | flush_in;

  always_comb begin
    wdata_fmt = rs2_in;
    wstrb_fmt = 4'b1111;
    case (load_size_in)
      2'b00: begin
        wdata_fmt = {4{rs2_in[7:0]}};
        wstrb_fmt = 4'b0001 << iadder_in[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{rs2_in[15:0]}};
        wstrb_fmt = 4'b0011 << {iadder_in[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = dmem_rdata_in >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      cnt            <= '0;
      discard        <= 1'b0;
      off_q          <= 2'b00;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      dmem_req_out   <= 1'b0;
      dmem_we_out    <= 1'b0;
      dmem_addr_out  <= '0;
      dmem_wdata_out <= '0;
      dmem_wstrb_out <= '0;
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      bus_err_out    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= BUSY;
            cnt            <= '0;
            discard        <= 1'b0;
            off_q          <= iadder_in[1:0];
            size_q         <= load_size_in;
            uns_q          <= load_unsigned_in;
            dmem_req_out   <= 1'b1;
            dmem_we_out    <= mem_wr_req_in;
            dmem_addr_out  <= {iadder_in[31:2], 2'b00};
            dmem_wdata_out <= wdata_fmt;
            dmem_wstrb_out <= mem_wr_req_in ? wstrb_fmt : 4'b0000;
          end
        end
        BUSY: begin
          discard <= drop;
          if (dmem_ready_in) begin
            state        <= IDLE;
            dmem_req_out <= 1'b0;
            dmem_we_out  <= 1'b0;
            if (!drop) begin
              if (dmem_err_in) begin
                bus_err_out <= 1'b1;
              end else if (!dmem_we_out) begin
                load_data_out  <= load_ext;
                load_valid_out <= 1'b1;
              end
            end
          end else if (timeout_hit) begin
            state        <= IDLE;
            dmem_req_out <= 1'b0;
            dmem_we_out  <= 1'b0;
            bus_err_out  <= ~drop;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msrv32_lsu_bus.sv
// Directed-vector bench for msrv32_lsu_bus (TIMEOUT=4 so the timeout path is short).
module tb_msrv32_lsu_bus;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        mem_wr_req_in = 1'b0, load_req_in = 1'b0, misaligned_load_in = 1'b0, flush_in = 1'b0;
  logic [1:0]  load_size_in = 2'b00;
  logic        load_unsigned_in = 1'b0;
  logic [31:0] iadder_in = '0, rs2_in = '0;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_wstrb_out;
  logic        dmem_ready_in = 1'b0;
  logic [31:0] dmem_rdata_in = '0;
  logic        dmem_err_in = 1'b0;
  logic        lsu_stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out, bus_err_out;

  int vectors = 0;
  int miscompares = 0;

  msrv32_lsu_bus #(.TIMEOUT(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .mem_wr_req_in(mem_wr_req_in), .load_req_in(load_req_in),
    .misaligned_load_in(misaligned_load_in), .flush_in(flush_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .iadder_in(iadder_in), .rs2_in(rs2_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_wstrb_out(dmem_wstrb_out), .dmem_ready_in(dmem_ready_in),
    .dmem_rdata_in(dmem_rdata_in), .dmem_err_in(dmem_err_in),
    .lsu_stall_out(lsu_stall_out), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req",   32'(dmem_req_out), 32'd0);
    chk("rst_stall", 32'(lsu_stall_out), 32'd0);
    chk("rst_addr",  dmem_addr_out, 32'h0);
    chk("rst_wdata", dmem_wdata_out, 32'h0);
    chk("rst_ldata", load_data_out, 32'h0);
    chk("rst_pulse", {30'd0, load_valid_out, bus_err_out}, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // Store byte at 0x1003 with three wait states
    mem_wr_req_in = 1'b1; load_size_in = 2'b00; iadder_in = 32'h1003; rs2_in = 32'h0000_00A5;
    #1 chk("sb_stall_acc", 32'(lsu_stall_out), 32'd1);
    tick();
    mem_wr_req_in = 1'b0;
    chk("sb_req",   32'(dmem_req_out), 32'd1);
    chk("sb_we",    32'(dmem_we_out), 32'd1);
    chk("sb_addr",  dmem_addr_out, 32'h1000);
    chk("sb_wdata", dmem_wdata_out, 32'hA5A5_A5A5);
    chk("sb_wstrb", 32'(dmem_wstrb_out), 32'h8);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sb_stall_wait", 32'(lsu_stall_out), 32'd1);
      chk("sb_req_wait", 32'(dmem_req_out), 32'd1);
    end
    tick();
    dmem_ready_in = 1'b1;
    tick();
    dmem_ready_in = 1'b0;
    chk("sb_req_done", 32'(dmem_req_out), 32'd0);
    chk("sb_stall_done", 32'(lsu_stall_out), 32'd0);
    chk("sb_pulses", {30'd0, load_valid_out, bus_err_out}, 32'd0);

    // Signed half load at 0x2002, zero-wait
    load_req_in = 1'b1; load_size_in = 2'b01; load_unsigned_in = 1'b0; iadder_in = 32'h2002;
    tick();
    load_req_in = 1'b0;
    chk("lh_req",   32'(dmem_req_out), 32'd1);
    chk("lh_we",    32'(dmem_we_out), 32'd0);
    chk("lh_wstrb", 32'(dmem_wstrb_out), 32'h0);
    chk("lh_addr",  dmem_addr_out, 32'h2000);
    dmem_ready_in = 1'b1; dmem_rdata_in = 32'h8001_0000;
    tick();
    dmem_ready_in = 1'b0;
    chk("lh_valid", 32'(load_valid_out), 32'd1);
    chk("lh_data",  load_data_out, 32'hFFFF_8001);
    // Back-to-back: unsigned half accepted while load_valid pulses
    load_req_in = 1'b1; load_unsigned_in = 1'b1;
    #1 chk("lhu_stall_b2b", 32'(lsu_stall_out), 32'd1);
    tick();
    load_req_in = 1'b0;
    chk("lhu_req_b2b", 32'(dmem_req_out), 32'd1);
    chk("lh_valid_once", 32'(load_valid_out), 32'd0);
    chk("lh_data_hold", load_data_out, 32'hFFFF_8001);
    dmem_ready_in = 1'b1;
    tick();
    dmem_ready_in = 1'b0;
    chk("lhu_valid", 32'(load_valid_out), 32'd1);
    chk("lhu_data",  load_data_out, 32'h0000_8001);
    tick();

    // Store half at 0x3002: upper lanes
    mem_wr_req_in = 1'b1; load_size_in = 2'b01; iadder_in = 32'h3002; rs2_in = 32'hDEAD_BEEF;
    tick();
    mem_wr_req_in = 1'b0;
    chk("sh_wdata", dmem_wdata_out, 32'hBEEF_BEEF);
    chk("sh_wstrb", 32'(dmem_wstrb_out), 32'hC);
    dmem_ready_in = 1'b1;
    tick();
    dmem_ready_in = 1'b0;

    // Signed byte load at offset 1
    load_req_in = 1'b1; load_size_in = 2'b00; load_unsigned_in = 1'b0; iadder_in = 32'h3001;
    tick();
    load_req_in = 1'b0;
    dmem_ready_in = 1'b1; dmem_rdata_in = 32'h0000_8000;
    tick();
    dmem_ready_in = 1'b0;
    chk("lb_data", load_data_out, 32'hFFFF_FF80);

    // Misaligned load and flushed request are not accepted
    load_req_in = 1'b1; misaligned_load_in = 1'b1; load_size_in = 2'b10;
    #1 chk("mis_stall", 32'(lsu_stall_out), 32'd0);
    tick();
    chk("mis_req", 32'(dmem_req_out), 32'd0);
    load_req_in = 1'b0; misaligned_load_in = 1'b0;
    mem_wr_req_in = 1'b1; flush_in = 1'b1;
    #1 chk("flq_stall", 32'(lsu_stall_out), 32'd0);
    tick();
    chk("flq_req", 32'(dmem_req_out), 32'd0);
    mem_wr_req_in = 1'b0; flush_in = 1'b0;

    // Timeout: ready never comes
    load_req_in = 1'b1; load_size_in = 2'b10; iadder_in = 32'h4000;
    tick();
    load_req_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_hi", 32'(dmem_req_out), 32'd1);
      chk("to_err_lo", 32'(bus_err_out), 32'd0);
      if (i < 3) tick();
    end
    tick();
    chk("to_req_drop", 32'(dmem_req_out), 32'd0);
    chk("to_err",      32'(bus_err_out), 32'd1);
    chk("to_stall",    32'(lsu_stall_out), 32'd0);
    tick();
    chk("to_err_once", 32'(bus_err_out), 32'd0);

    // Flush mid-load: bus completes, result discarded
    load_req_in = 1'b1; load_size_in = 2'b10; iadder_in = 32'h5000;
    tick();
    load_req_in = 1'b0; flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("fl_stall_busy", 32'(lsu_stall_out), 32'd1);
    chk("fl_req_busy",   32'(dmem_req_out), 32'd1);
    tick();
    dmem_ready_in = 1'b1; dmem_rdata_in = 32'h1234_5678;
    tick();
    dmem_ready_in = 1'b0;
    chk("fl_no_valid", {30'd0, load_valid_out, bus_err_out}, 32'd0);
    chk("fl_data_kept", load_data_out, 32'hFFFF_FF80);
    load_req_in = 1'b1; iadder_in = 32'h6000;
    tick();
    load_req_in = 1'b0;
    dmem_ready_in = 1'b1; dmem_rdata_in = 32'hCAFE_F00D;
    tick();
    dmem_ready_in = 1'b0;
    chk("fl_next_valid", 32'(load_valid_out), 32'd1);
    chk("fl_next_data",  load_data_out, 32'hCAFE_F00D);

    // Error response
    load_req_in = 1'b1; iadder_in = 32'h6004;
    tick();
    load_req_in = 1'b0;
    dmem_ready_in = 1'b1; dmem_err_in = 1'b1;
    tick();
    dmem_ready_in = 1'b0; dmem_err_in = 1'b0;
    chk("err_pulses", {30'd0, load_valid_out, bus_err_out}, 32'd1);

    // Asynchronous reset while BUSY
    load_req_in = 1'b1; iadder_in = 32'h6008;
    tick();
    load_req_in = 1'b0;
    chk("ar_req_pre", 32'(dmem_req_out), 32'd1);
    #1 rst_n_in = 1'b0;
    #1;
    chk("ar_req",   32'(dmem_req_out), 32'd0);
    chk("ar_stall", 32'(lsu_stall_out), 32'd0);
    chk("ar_addr",  dmem_addr_out, 32'h0);
    chk("ar_ldata", load_data_out, 32'h0);
    #1 rst_n_in = 1'b1;
    mem_wr_req_in = 1'b1; load_size_in = 2'b10; iadder_in = 32'h7000; rs2_in = 32'h1122_3344;
    tick();
    mem_wr_req_in = 1'b0;
    chk("ar_sw_wdata", dmem_wdata_out, 32'h1122_3344);
    chk("ar_sw_wstrb", 32'(dmem_wstrb_out), 32'hF);
    chk("ar_sw_addr",  dmem_addr_out, 32'h7000);
    dmem_ready_in = 1'b1;
    tick();
    dmem_ready_in = 1'b0;
    chk("ar_sw_done", {30'd0, dmem_req_out, lsu_stall_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
